// File: rtl/spi_mem_master.sv
// Request-side SPI master: serialises one write/read per handshake to spi_slave over
// cs/mosi, collects read data from miso and returns a one-cycle response.
module spi_mem_master #(
   parameter int TIMEOUT = 64,
   parameter int TO_W    = 7
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_wr,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_err,
   output logic       cs,
   output logic       mosi,
   input  logic       miso,
   input  logic       s_ready,
   input  logic       s_op_done
);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_OPBIT, S_ADDR, S_WDATA,
      S_WAIT_RDY, S_RDATA, S_WAIT_DONE, S_RESP
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d, cnt_inc;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            wr_q, wr_d;
   logic [7:0]      addr_q, addr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            cs_q, cs_d;
   logic            mosi_q, mosi_d;
   logic            req_ready_q, req_ready_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [7:0]      rsp_rdata_q, rsp_rdata_d;
   logic            rsp_err_q, rsp_err_d;

   assign cnt_inc = cnt_q + 3'd1;

   // Outputs are computed one cycle ahead so every pin comes straight from a flop.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      to_cnt_d    = to_cnt_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      cs_d        = cs_q;
      mosi_d      = mosi_q;
      req_ready_d = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = 8'h00;
      rsp_err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready_d = 1'b1;
            cs_d        = 1'b1;
            mosi_d      = 1'b0;
            if (req_valid && req_ready_q) begin
               wr_d        = req_wr;
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               req_ready_d = 1'b0;
               cs_d        = 1'b0;
               state_d     = S_START;
            end
         end
         S_START: begin
            mosi_d  = wr_q;
            state_d = S_OPBIT;
         end
         S_OPBIT: begin
            mosi_d  = addr_q[0];
            cnt_d   = 3'd0;
            state_d = S_ADDR;
         end
         S_ADDR: begin
            if (cnt_q == 3'd7) begin
               cnt_d = 3'd0;
               if (wr_q) begin
                  mosi_d  = wdata_q[0];
                  state_d = S_WDATA;
               end else begin
                  // Release cs before the slave finishes so it never sees a restart.
                  cs_d     = 1'b1;
                  mosi_d   = 1'b0;
                  to_cnt_d = '0;
                  state_d  = S_WAIT_RDY;
               end
            end else begin
               mosi_d = addr_q[cnt_inc];
               cnt_d  = cnt_inc;
            end
         end
         S_WDATA: begin
            if (cnt_q == 3'd7) begin
               cs_d     = 1'b1;
               mosi_d   = 1'b0;
               to_cnt_d = '0;
               state_d  = S_WAIT_DONE;
            end else begin
               mosi_d = wdata_q[cnt_inc];
               cnt_d  = cnt_inc;
            end
         end
         S_WAIT_RDY: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (s_ready) begin
               cnt_d   = 3'd0;
               state_d = S_RDATA;
            end else if (to_cnt_q == TO_LAST) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               state_d     = S_RESP;
            end
         end
         S_RDATA: begin
            rdata_d[cnt_q] = miso;
            if (cnt_q == 3'd7) begin
               to_cnt_d = '0;
               state_d  = S_WAIT_DONE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_WAIT_DONE: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (s_op_done) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = wr_q ? 8'h00 : rdata_q;
               state_d     = S_RESP;
            end else if (to_cnt_q == TO_LAST) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            req_ready_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         cnt_q       <= 3'd0;
         to_cnt_q    <= '0;
         wr_q        <= 1'b0;
         addr_q      <= 8'h00;
         wdata_q     <= 8'h00;
         rdata_q     <= 8'h00;
         cs_q        <= 1'b1;
         mosi_q      <= 1'b0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 8'h00;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         to_cnt_q    <= to_cnt_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         cs_q        <= cs_d;
         mosi_q      <= mosi_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign cs        = cs_q;
   assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: behavioural slave with a 256-byte memory, directed requests,
// and a response scoreboard checking rdata, err and completion cycle.
module tb_spi_mem_master;
   localparam int TIMEOUT = 64;

   logic       clk, rstn;
   logic       req_valid, req_ready, req_wr;
   logic [7:0] req_addr, req_wdata;
   logic       rsp_valid, rsp_err;
   logic [7:0] rsp_rdata;
   logic       cs, mosi, miso;
   logic       s_rdy_m, s_done_m, force_done, slave_en;

   spi_mem_master #(.TIMEOUT(TIMEOUT), .TO_W(7)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .cs(cs), .mosi(mosi), .miso(miso),
      .s_ready(s_rdy_m), .s_op_done(s_done_m | force_done)
   );

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      int         lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0, n_fail = 0;
   int   cyc = 0, acc_cyc = 0;

   // slave model state and captures
   logic [7:0] mem [256];
   bit         active;
   int         scnt;
   logic       s_m0, s_op, cs_pre, cs_post;
   logic [7:0] s_addr, s_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Scoreboard monitor
   initial forever begin
      @(negedge clk);
      if (rstn && rsp_valid) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL spurious_rsp: got rsp_valid, expected none (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_rdata", {24'h0, rsp_rdata}, {24'h0, e.rdata});
            chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
            chk("rsp_latency", cyc - acc_cyc, e.lat);
         end
      end
      if (rstn && req_valid && req_ready) acc_cyc = cyc + 1;
   end

   // Behavioural slave, clocked mid-cycle; scnt equals the master's cycle index n.
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      active = 0; scnt = 0;
      s_rdy_m = 0; s_done_m = 0; miso = 0;
      forever begin
         @(negedge clk);
         if (!rstn || !slave_en) begin
            active = 0; s_rdy_m = 0; s_done_m = 0; miso = 0;
         end else if (!active) begin
            if (!cs) begin
               active = 1; scnt = 0; s_m0 = mosi;
            end
         end else begin
            scnt++;
            if (scnt == 1) s_op = mosi;
            else if (scnt <= 9) s_addr[scnt-2] = mosi;
            if (scnt == (s_op ? 17 : 9))  cs_pre  = cs;
            if (scnt == (s_op ? 18 : 10)) cs_post = cs;
            if (s_op) begin
               if (scnt >= 10 && scnt <= 17) s_data[scnt-10] = mosi;
               if (scnt == 19) begin s_done_m = 1; mem[s_addr] = s_data; end
               if (scnt == 20) begin s_done_m = 0; active = 0; end
            end else begin
               if (scnt == 11) s_rdy_m = 1;
               if (scnt >= 12 && scnt <= 19) begin s_rdy_m = 0; miso = mem[s_addr][scnt-12]; end
               if (scnt == 20) begin miso = 0; s_done_m = 1; end
               if (scnt == 21) begin s_done_m = 0; active = 0; end
            end
         end
      end
   end

   task automatic push(input logic [7:0] r, input logic e, input int l);
      exp_t x;
      x.rdata = r; x.err = e; x.lat = l;
      exp_q.push_back(x);
   endtask

   // Returns #1 after the acceptance edge (cycle n=0).
   task automatic send(input logic wr, input logic [7:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      req_valid = 1; req_wr = wr; req_addr = a; req_wdata = d;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req_ready) break;
      end
      chk("req_ready_wait", {31'h0, req_ready}, 32'h1);
      @(posedge clk); #1;
      req_valid = 0;
   endtask

   task automatic wait_rsp();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
      chk("rsp_pending", exp_q.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      int c_first;
      rstn = 0; req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
      force_done = 0; slave_en = 1;
      repeat (3) @(negedge clk);
      chk("rst_cs", {31'h0, cs}, 32'h1);
      chk("rst_mosi", {31'h0, mosi}, 32'h0);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", {24'h0, rsp_rdata}, 32'h0);
      chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
      #1 rstn = 1;
      @(negedge clk);
      chk("ready_after_rst", {31'h0, req_ready}, 32'h1);

      // 1: write 0x05 <- 0xA7
      push(8'h00, 1'b0, 20);
      send(1'b1, 8'h05, 8'hA7);
      wait_rsp();
      chk("t1_mosi_n0", {31'h0, s_m0}, 32'h0);
      chk("t1_opbit", {31'h0, s_op}, 32'h1);
      chk("t1_addr", {24'h0, s_addr}, 32'h05);
      chk("t1_wdata", {24'h0, s_data}, 32'hA7);
      chk("t1_cs_n17", {31'h0, cs_pre}, 32'h0);
      chk("t1_cs_n18", {31'h0, cs_post}, 32'h1);

      // 2: read 0x05
      push(8'hA7, 1'b0, 21);
      send(1'b0, 8'h05, 8'hFF);
      wait_rsp();
      chk("t2_opbit", {31'h0, s_op}, 32'h0);
      chk("t2_cs_n9", {31'h0, cs_pre}, 32'h0);
      chk("t2_cs_n10", {31'h0, cs_post}, 32'h1);

      // 3: back-to-back write then read with req_valid held high
      push(8'h00, 1'b0, 20);
      push(8'h3C, 1'b0, 21);
      @(posedge clk); #1;
      req_valid = 1; req_wr = 1; req_addr = 8'h1F; req_wdata = 8'h3C;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req_ready) break;
      end
      c_first = cyc + 1;
      @(posedge clk); #1;
      req_wr = 0; req_wdata = 8'h00;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req_ready) break;
      end
      chk("t3_second_accept", cyc + 1 - c_first, 22);
      @(posedge clk); #1;
      req_valid = 0;
      wait_rsp();

      // 4: slave disconnected -> timeout in WAIT_RDY
      slave_en = 0;
      push(8'h00, 1'b1, 10 + TIMEOUT);
      send(1'b0, 8'h33, 8'h00);
      wait_rsp();
      slave_en = 1;

      // 5: reset at n=12 of a write
      send(1'b1, 8'h10, 8'h55);
      for (int i = 0; i < 50 && (cyc - acc_cyc) < 12; i++) @(negedge clk);
      #1 rstn = 0;
      #1;
      chk("t5_cs_async", {31'h0, cs}, 32'h1);
      chk("t5_ready_in_rst", {31'h0, req_ready}, 32'h0);
      repeat (2) @(negedge clk);
      #1 rstn = 1;
      #1 chk("t5_ready_at_release", {31'h0, req_ready}, 32'h0);
      @(negedge clk);
      chk("t5_ready_after", {31'h0, req_ready}, 32'h1);
      chk("t5_mem_untouched", {24'h0, mem[8'h10]}, 32'h00);
      push(8'h00, 1'b0, 20);
      send(1'b1, 8'h10, 8'h66);
      wait_rsp();
      push(8'h66, 1'b0, 21);
      send(1'b0, 8'h10, 8'h00);
      wait_rsp();

      // 6: spurious s_op_done during ADDR, req_addr changed mid-transfer
      push(8'h00, 1'b0, 20);
      send(1'b1, 8'h42, 8'h99);
      req_addr = 8'hBD; req_wdata = 8'h11; req_wr = 0;
      repeat (3) @(negedge clk);
      force_done = 1;
      repeat (5) @(negedge clk);
      force_done = 0;
      wait_rsp();
      chk("t6_addr", {24'h0, s_addr}, 32'h42);
      chk("t6_wdata", {24'h0, s_data}, 32'h99);
      push(8'h99, 1'b0, 21);
      send(1'b0, 8'h42, 8'h00);
      wait_rsp();

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
